// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the two-client UART transmit arbiter.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [1:0] TX_ADDR_DEFAULT = 2'd0;
  localparam logic       IORW_READ       = 1'b1;
  localparam logic       IORW_WRITE      = 1'b0;

  function automatic logic [1:0] client_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/tx_arbiter_if.sv
// Client request/ack and transmitter bus signals of the tx arbiter.
// master = arbiter side, slave = clients plus transmitter side.
interface tx_arbiter_if;
  logic [1:0] req;
  logic [7:0] data0;
  logic [7:0] data1;
  logic [1:0] ack;
  logic       busy;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] databus;
  logic       err;

  modport master (
    input  req, data0, data1, tbr,
    output ack, busy, iocs, iorw, ioaddr, databus, err
  );

  modport slave (
    output req, data0, data1, tbr,
    input  ack, busy, iocs, iorw, ioaddr, databus, err
  );
endinterface

// File: rtl/tx_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a sole requester wins,
// on contention the client that did not win last time wins.
module rr_arb2
  import tx_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_valid,
  output logic       o_idx
);

  assign o_valid = |i_req;
  assign o_idx   = (i_req == 2'b11) ? ~i_last : i_req[1];

endmodule

// File: rtl/tx_arbiter.sv
// Shares one UART transmitter between two byte-stream clients (round-robin).
// Optional watchdog on the post-write wait is enabled by TXARB_WATCHDOG_EN.
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter logic [1:0] TX_ADDR = TX_ADDR_DEFAULT,
  parameter int         TIMEOUT = 4096,
  parameter int         CNT_W   = 13
) (
  input  logic         clk,
  input  logic         rst,
  tx_arbiter_if.master bus
);

  if ((64'd1 << CNT_W) <= 64'(TIMEOUT)) begin : g_cnt_w_too_small
    $error("tx_arbiter: CNT_W too narrow to hold TIMEOUT");
  end

  state_t     r_state;
  state_t     w_state_next;
  logic       r_last;
  logic       r_winner;
  logic [7:0] r_databus;
  logic       r_iocs;
  logic       r_iorw;
  logic [1:0] r_ioaddr;
  logic [1:0] r_ack;
  logic       r_busy;
  logic       r_err;

  logic       w_grant_valid;
  logic       w_grant_idx;
  logic       w_take;
  logic       w_timeout;

  rr_arb2 u_rr_arb2 (
    .i_req   (bus.req),
    .i_last  (r_last),
    .o_valid (w_grant_valid),
    .o_idx   (w_grant_idx)
  );

  // Requests only matter in IDLE and only while the transmitter is free.
  assign w_take = (r_state == IDLE) && bus.tbr && w_grant_valid;

`ifdef TXARB_WATCHDOG_EN
  logic [CNT_W-1:0] r_cnt;
  logic             w_waiting;

  assign w_waiting = (r_state == WAIT_LOW) || (r_state == WAIT_DONE);

  // Cleared while in WRITE so the first WAIT_LOW cycle sees zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == WRITE) begin
      r_cnt <= '0;
    end else if (w_waiting) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_timeout = w_waiting && (r_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:      if (w_take)   w_state_next = WRITE;
      WRITE:                   w_state_next = WAIT_LOW;
      WAIT_LOW:  if (!bus.tbr) w_state_next = WAIT_DONE;
      WAIT_DONE: if (bus.tbr)  w_state_next = IDLE;
      default:                 w_state_next = IDLE;
    endcase
    if (w_timeout) begin
      w_state_next = IDLE;
    end
  end

  // Bus outputs are registered images of the current state, so the write
  // cycle appears on the bus the clock after the WRITE state is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_winner  <= 1'b0;
      r_databus <= 8'h00;
      r_iocs    <= 1'b0;
      r_iorw    <= IORW_READ;
      r_ioaddr  <= TX_ADDR;
      r_ack     <= 2'b00;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_take) begin
        r_last    <= w_grant_idx;
        r_winner  <= w_grant_idx;
        r_databus <= w_grant_idx ? bus.data1 : bus.data0;
      end
      r_iocs   <= (r_state == WRITE);
      r_iorw   <= (r_state == WRITE) ? IORW_WRITE : IORW_READ;
      r_ioaddr <= TX_ADDR;
      r_ack    <= (r_state == WRITE) ? client_onehot(r_winner) : 2'b00;
      r_busy   <= (r_state != IDLE);
      r_err    <= w_timeout;
    end
  end

  assign bus.iocs    = r_iocs;
  assign bus.iorw    = r_iorw;
  assign bus.ioaddr  = r_ioaddr;
  assign bus.databus = r_databus;
  assign bus.ack     = r_ack;
  assign bus.busy    = r_busy;
  assign bus.err     = r_err;

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: transaction-timing reference model,
// directed scenarios and a randomized client/transmitter phase.
module tb_tx_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tx_arbiter_if bus ();

  tx_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: a transaction starts at grant edge g, shows on the bus
  // after edge g+1, then lasts until tbr has been seen low and then high
  int         m_edge = 0;
  bit         m_last = 1'b1;
  bit         m_in_txn = 1'b0;
  int         m_grant_edge = 0;
  bit         m_seen_low = 1'b0;
  bit         m_win = 1'b0;
  bit         e_iocs = 1'b0;
  logic [1:0] e_ack = 2'b00;
  bit         e_busy = 1'b0;
  logic [7:0] e_databus = 8'h00;
  int         n_writes = 0;

  // transmitter model
  int tx_left = 0;
  int frame_len = 10;
  bit tbr_hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_edge();
    m_edge++;
    if (rst) begin
      e_iocs = 0; e_ack = 2'b00; e_busy = 0; e_databus = 8'h00;
      m_last = 1'b1; m_in_txn = 0;
      return;
    end
    e_busy = m_in_txn;
    e_iocs = m_in_txn && (m_edge == m_grant_edge + 1);
    e_ack  = e_iocs ? (m_win ? 2'b10 : 2'b01) : 2'b00;
    if (!m_in_txn) begin
      if (bus.tbr && bus.req != 2'b00) begin
        if (bus.req == 2'b11) m_win = ~m_last;
        else m_win = (bus.req == 2'b10);
        m_last = m_win;
        e_databus = m_win ? bus.data1 : bus.data0;
        m_in_txn = 1; m_grant_edge = m_edge; m_seen_low = 0;
      end
    end else if (m_edge >= m_grant_edge + 2) begin
      if (!m_seen_low) begin
        if (!bus.tbr) m_seen_low = 1;
      end else if (bus.tbr) begin
        m_in_txn = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("iocs", bus.iocs, e_iocs);
    check("iorw", bus.iorw, !e_iocs);
    check("ioaddr", bus.ioaddr, 2'd0);
    check("databus", bus.databus, e_databus);
    check("ack", bus.ack, e_ack);
    check("busy", bus.busy, e_busy);
    check("err", bus.err, 1'b0);
    if (e_iocs) begin
      n_writes++;
      $display("write %0d: client %0d data %02h t=%0t", n_writes, m_win, e_databus, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (e_iocs) tx_left = frame_len;
    else if (tx_left > 0) tx_left--;
    bus.tbr = (tx_left == 0) && !tbr_hold;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 2'b00;
    tick();
    tick();
    check("rst_iocs", bus.iocs, 1'b0);
    check("rst_iorw", bus.iorw, 1'b1);
    check("rst_ack", bus.ack, 2'b00);
    check("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((m_in_txn || tx_left != 0) && k < 300) begin
      tick();
      k++;
    end
    check("wait_idle_bound", (k < 300), 1'b1);
  endtask

  initial begin
    logic [7:0] wr_q[$];
    logic [7:0] exp_order [4];
    int k;
    int ack1_cnt;
    bit seen;
    logic [1:0] r;

    rst = 1'b1; bus.req = 2'b00; bus.data0 = 8'h00; bus.data1 = 8'h00; bus.tbr = 1'b1;

    // 1: single request, write cycle two clocks after req
    do_reset();
    bus.req = 2'b01; bus.data0 = 8'hA5;
    tick();
    check("t1_no_write_yet", bus.iocs, 1'b0);
    tick();
    check("t1_iocs", bus.iocs, 1'b1);
    check("t1_iorw", bus.iorw, 1'b0);
    check("t1_ioaddr", bus.ioaddr, 2'd0);
    check("t1_databus", bus.databus, 8'hA5);
    check("t1_ack", bus.ack, 2'b01);
    bus.req = 2'b00;
    tick();
    check("t1_busy", bus.busy, 1'b1);
    check("t1_ack_pulse", bus.ack, 2'b00);
    wait_idle();
    tick();
    check("t1_busy_done", bus.busy, 1'b0);

    // 2: continuous contention alternates clients
    do_reset();
    frame_len = 10;
    bus.data0 = 8'h11; bus.data1 = 8'h22; bus.req = 2'b11;
    k = 0;
    while (wr_q.size() < 4 && k < 300) begin
      tick();
      if (bus.iocs === 1'b1) wr_q.push_back(bus.databus);
      k++;
    end
    bus.req = 2'b00;
    exp_order = '{8'h11, 8'h22, 8'h11, 8'h22};
    check("t2_write_count", wr_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_q.size(); i++) check("t2_order", wr_q[i], exp_order[i]);
    wait_idle();

    // 3: transmitter held busy blocks grants
    tbr_hold = 1'b1; bus.tbr = 1'b0;
    bus.req = 2'b01; bus.data0 = 8'h5A;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("t3_hold_iocs", bus.iocs, 1'b0);
      check("t3_hold_ack", bus.ack, 2'b00);
    end
    tbr_hold = 1'b0; bus.tbr = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 && !seen; i++) begin
      tick();
      if (bus.iocs === 1'b1) seen = 1;
    end
    check("t3_write_after_release", seen, 1'b1);
    bus.req = 2'b00;
    wait_idle();

    // 4: a one-cycle req[1] pulse during WAIT_DONE is never granted
    bus.req = 2'b01; bus.data0 = 8'h3C;
    k = 0;
    while (!(m_in_txn && m_seen_low) && k < 50) begin
      tick();
      if (e_ack[0]) bus.req = 2'b00;
      k++;
    end
    check("t4_reach_wait_done", (k < 50), 1'b1);
    bus.req = 2'b10; bus.data1 = 8'h77;
    tick();
    bus.req = 2'b00;
    ack1_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.ack[1] === 1'b1) ack1_cnt++;
    end
    check("t4_no_ack1", ack1_cnt, 0);

    // 5: reset during WRITE aborts; last returns to 1
    do_reset();
    bus.req = 2'b01; bus.data0 = 8'hC3;
    tick();
    rst = 1'b1;
    tick();
    check("t5_iocs", bus.iocs, 1'b0);
    check("t5_iorw", bus.iorw, 1'b1);
    check("t5_ack", bus.ack, 2'b00);
    check("t5_busy", bus.busy, 1'b0);
    rst = 1'b0;
    bus.req = 2'b11; bus.data1 = 8'h99;
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      tick();
      if (bus.iocs === 1'b1) begin
        seen = 1;
        check("t5_grant_client0", bus.ack, 2'b01);
        check("t5_data", bus.databus, 8'hC3);
      end
    end
    check("t5_write_seen", seen, 1'b1);
    bus.req = 2'b00;
    wait_idle();

    // 6: randomized clients, frame lengths, stalls and resets
    k = n_writes;
    for (int c = 0; c < 4000; c++) begin
      frame_len = $urandom_range(1, 12);
      if ($urandom_range(0, 99) < 2) tbr_hold = !tbr_hold;
      if (tbr_hold) bus.tbr = 1'b0;
      rst = ($urandom_range(0, 399) == 0);
      r = bus.req;
      for (int i = 0; i < 2; i++) begin
        if (r[i] && e_ack[i]) begin
          r[i] = ($urandom_range(0, 3) == 0);
          if (i == 0) bus.data0 = 8'($urandom_range(0, 255));
          else bus.data1 = 8'($urandom_range(0, 255));
        end else if (!r[i] && $urandom_range(0, 99) < 20) begin
          r[i] = 1'b1;
          if (i == 0) bus.data0 = 8'($urandom_range(0, 255));
          else bus.data1 = 8'($urandom_range(0, 255));
        end else if (r[i] && !(m_in_txn && m_win == i) && $urandom_range(0, 99) < 3) begin
          r[i] = 1'b0;
        end
      end
      bus.req = r;
      tick();
    end
    rst = 1'b0;
    check("t6_random_writes", (n_writes - k > 20), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at t=%0t, required to finish", $time);
    $fatal(1);
  end

endmodule
